// File: rtl/csr_hpm.sv
// Machine counter CSR block: mcycle, minstret, NUM_HPM event counters, mcountinhibit, user shadows.
// Define CSR_HPM_OVERFLOW_EN to add the mhpmevent OF bit and the lcofip overflow interrupt.
module csr_hpm #(
  parameter int NUM_HPM = 4,
  parameter int EVENT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               crden,
  input  logic [11:0]        craddr,
  output logic [31:0]        cdata,
  output logic               chit,
  input  logic               cwren,
  input  logic [11:0]        cwaddr,
  input  logic [31:0]        cwdata,
  input  logic               valid,
  input  logic [EVENT_W-1:0] events,  // "event" is a reserved word
  output logic               lcofip
);

  localparam int NCNT = NUM_HPM + 3;

  function automatic logic is_cnt(input int i);
    return (i == 0) || (i >= 2 && i < NCNT);
  endfunction

  logic [63:0]        cnt_reg [NCNT];
  logic [7:0]         sel_reg [NUM_HPM];
  logic [NCNT-1:0]    inhibit_reg;
  logic [NUM_HPM-1:0] of_bits;
  logic [NCNT-1:0]    inc;
  logic [NCNT-1:0]    wr_lo;
  logic [NCNT-1:0]    wr_hi;
  logic [NUM_HPM-1:0] wr_evt;
  logic               wr_inh;
  logic               wr_cnt_space;
  logic [255:0]       ev_ext;
  logic [31:0]        rd_data;
  logic               rd_hit;

  // Bit 0 is permanently 0, so a selector of 0 or above EVENT_W never counts.
  assign ev_ext = 256'(events) << 1;

  always_comb begin
    wr_cnt_space = cwren && (cwaddr[11:8] == 4'hB) && (cwaddr[6:5] == 2'b00);
    wr_lo = '0;
    wr_hi = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (is_cnt(i)) begin
        wr_lo[i] = wr_cnt_space && !cwaddr[7] && (cwaddr[4:0] == 5'(i));
        wr_hi[i] = wr_cnt_space &&  cwaddr[7] && (cwaddr[4:0] == 5'(i));
      end
    end
    wr_inh = cwren && (cwaddr == 12'h320);
    for (int j = 0; j < NUM_HPM; j++)
      wr_evt[j] = cwren && (cwaddr == 12'h320 + 12'(j + 3));
  end

  always_comb begin
    inc    = '0;
    inc[0] = !inhibit_reg[0];
    inc[2] = valid && !inhibit_reg[2];
    for (int j = 0; j < NUM_HPM; j++)
      inc[j+3] = ev_ext[sel_reg[j]] && !inhibit_reg[j+3];
  end

  // A write to either half beats the increment for that whole counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCNT; i++) cnt_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NCNT; i++) begin
        if (is_cnt(i)) begin
          if (wr_lo[i])       cnt_reg[i][31:0]  <= cwdata;
          else if (wr_hi[i])  cnt_reg[i][63:32] <= cwdata;
          else if (inc[i])    cnt_reg[i]        <= cnt_reg[i] + 64'd1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inhibit_reg <= '0;
      for (int j = 0; j < NUM_HPM; j++) sel_reg[j] <= '0;
    end else begin
      if (wr_inh) inhibit_reg <= {cwdata[NCNT-1:2], 1'b0, cwdata[0]};
      for (int j = 0; j < NUM_HPM; j++)
        if (wr_evt[j]) sel_reg[j] <= cwdata[7:0];
    end
  end

`ifdef CSR_HPM_OVERFLOW_EN
  logic [NUM_HPM-1:0] of_reg;
  logic [NUM_HPM-1:0] of_next;
  logic               lcofip_reg;

  // An increment wrap sets OF even if software writes the event register that cycle.
  always_comb begin
    for (int j = 0; j < NUM_HPM; j++)
      of_next[j] = (wr_evt[j] ? cwdata[31] : of_reg[j]) |
                   (inc[j+3] && !wr_lo[j+3] && !wr_hi[j+3] && (&cnt_reg[j+3]));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      of_reg     <= '0;
      lcofip_reg <= 1'b0;
    end else begin
      of_reg     <= of_next;
      lcofip_reg <= |of_next;
    end
  end

  assign of_bits = of_reg;
  assign lcofip  = lcofip_reg;
`else
  assign of_bits = '0;
  assign lcofip  = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    if ((craddr[11:8] == 4'hB || craddr[11:8] == 4'hC) && craddr[6:5] == 2'b00) begin
      for (int i = 0; i < NCNT; i++) begin
        if (is_cnt(i) && craddr[4:0] == 5'(i)) begin
          rd_hit  = 1'b1;
          rd_data = craddr[7] ? cnt_reg[i][63:32] : cnt_reg[i][31:0];
        end
      end
    end
    if (craddr == 12'h320) begin
      rd_hit  = 1'b1;
      rd_data = 32'(inhibit_reg);
    end
    for (int j = 0; j < NUM_HPM; j++) begin
      if (craddr == 12'h320 + 12'(j + 3)) begin
        rd_hit  = 1'b1;
        rd_data = {of_bits[j], 23'd0, sel_reg[j]};
      end
    end
  end

  assign chit  = reset && crden && rd_hit;
  assign cdata = chit ? rd_data : 32'd0;

endmodule

// File: tb/tb_csr_hpm.sv
// Directed scoreboard bench for csr_hpm (NUM_HPM=4, EVENT_W=8); builds with or without CSR_HPM_OVERFLOW_EN.
module tb_csr_hpm;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        crden = 1'b0;
  logic [11:0] craddr = '0;
  logic [31:0] cdata;
  logic        chit;
  logic        cwren = 1'b0;
  logic [11:0] cwaddr = '0;
  logic [31:0] cwdata = '0;
  logic        valid = 1'b0;
  logic [7:0]  events = '0;
  logic        lcofip;

`ifdef CSR_HPM_OVERFLOW_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        hit;
    logic        lcof;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  csr_hpm #(.NUM_HPM(4), .EVENT_W(8)) dut (
    .clock  (clock),
    .reset  (reset),
    .crden  (crden),
    .craddr (craddr),
    .cdata  (cdata),
    .chit   (chit),
    .cwren  (cwren),
    .cwaddr (cwaddr),
    .cwdata (cwdata),
    .valid  (valid),
    .events (events),
    .lcofip (lcofip)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
    end
  endtask

  // Monitor: every read strobe consumes one expected entry.
  always @(negedge clock) begin
    if (crden) begin
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_read: addr 0x%03h with no expected entry", craddr);
      end else begin
        mon_e = expq.pop_front();
        check({mon_e.name, ".cdata"},  cdata,         mon_e.data);
        check({mon_e.name, ".chit"},   32'(chit),     32'(mon_e.hit));
        check({mon_e.name, ".lcofip"}, 32'(lcofip),   32'(mon_e.lcof));
        $display("read %-22s addr=0x%03h cdata=0x%08h chit=%0b lcofip=%0b",
                 mon_e.name, craddr, cdata, chit, lcofip);
      end
    end
  end

  task automatic rd(input logic [11:0] a, input logic [31:0] d, input logic h,
                    input logic l, input string nm);
    exp_t e;
    e.name = nm; e.data = d; e.hit = h; e.lcof = l;
    expq.push_back(e);
    crden = 1'b1;
    craddr = a;
    @(posedge clock); #1;
    crden = 1'b0;
    craddr = '0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    cwren = 1'b1;
    cwaddr = a;
    cwdata = d;
    @(posedge clock); #1;
    cwren = 1'b0;
    $display("write addr=0x%03h data=0x%08h", a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    reset = 1'b1;
    idle(10);
    rd(12'hB00, 32'd10, 1'b1, 1'b0, "mcycle_idle10");
    rd(12'hB02, 32'd0,  1'b1, 1'b0, "minstret_idle");
    rd(12'h7C0, 32'd0,  1'b0, 1'b0, "unimplemented");
    rd(12'hB80, 32'd0,  1'b1, 1'b0, "mcycle_hi");

    // minstret inhibit then count
    wr(12'h320, 32'h4);
    valid = 1'b1; idle(5); valid = 1'b0;
    rd(12'hB02, 32'd0, 1'b1, 1'b0, "minstret_inhibited");
    wr(12'h320, 32'h0);
    valid = 1'b1; idle(3); valid = 1'b0;
    rd(12'hC02, 32'd3, 1'b1, 1'b0, "minstret_shadow");

    // event selection
    wr(12'h323, 32'h2);
    events = 8'h02; idle(7);
    events = 8'h01; idle(4);
    events = 8'h00;
    rd(12'hB03, 32'd7, 1'b1, 1'b0, "hpm3_event2");
    rd(12'hB83, 32'd0, 1'b1, 1'b0, "hpm3_hi");
    rd(12'h323, 32'h2, 1'b1, 1'b0, "evt3_sel");
    wr(12'h324, 32'h9);
    events = 8'hFF; idle(3); events = 8'h00;
    rd(12'hB04, 32'd0, 1'b1, 1'b0, "hpm4_sel_out_of_range");
    rd(12'h324, 32'h9, 1'b1, 1'b0, "evt4_sel");

    // writable inhibit bits: 0, 2, 3..6
    wr(12'h320, 32'hFFFF_FFFF);
    rd(12'h320, 32'h7D, 1'b1, 1'b0, "inhibit_mask");
    wr(12'h320, 32'h0);

    // low-to-high carry
    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'hB83, 32'h0);
    events = 8'h02; idle(1); events = 8'h00;
    rd(12'hB03, 32'd0, 1'b1, 1'b0, "carry_lo");
    rd(12'hB83, 32'd1, 1'b1, 1'b0, "carry_hi");

    // shadows are read-only
    wr(12'hC03, 32'h5);
    rd(12'hC03, 32'd0, 1'b1, 1'b0, "shadow_write_ignored");
    rd(12'hC83, 32'd1, 1'b1, 1'b0, "shadow_hi");

    // write beats increment
    wr(12'hB00, 32'h100);
    rd(12'hB00, 32'h100, 1'b1, 1'b0, "collision");

    // 64-bit wrap of hpm3
    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'hB83, 32'hFFFF_FFFF);
    events = 8'h02; idle(1); events = 8'h00;
    rd(12'hB03, 32'd0, 1'b1, OVF, "wrap_lo");
    rd(12'hB83, 32'd0, 1'b1, OVF, "wrap_hi");
    rd(12'h323, OVF ? 32'h8000_0002 : 32'h2, 1'b1, OVF, "of_after_wrap");
    wr(12'h323, 32'h2);
    rd(12'h323, 32'h2, 1'b1, 1'b0, "of_cleared");
    wr(12'h323, 32'h8000_0002);
    rd(12'h323, OVF ? 32'h8000_0002 : 32'h2, 1'b1, OVF, "of_sw_set");
    wr(12'h323, 32'h0);

    // asynchronous reset mid-count
    valid = 1'b1; idle(2);
    #2 reset = 1'b0;
    rd(12'hB02, 32'd0, 1'b0, 1'b0, "read_in_reset");
    valid = 1'b0;
    reset = 1'b1;
    rd(12'hB00, 32'd0, 1'b1, 1'b0, "mcycle_after_reset");
    rd(12'hB00, 32'd1, 1'b1, 1'b0, "mcycle_resumes");
    rd(12'h323, 32'd0, 1'b1, 1'b0, "evt3_after_reset");
    idle(1);

    n_checks++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
